// File: rtl/exc_commit.sv
// WB-stage exception / ERTN commit unit.
// Latches the instruction leaving MEM, prioritises its exception flags with the
// CSR interrupt request, drives the CSR commit inputs and the pipeline flush,
// and holds a single flush-recovery cycle so nothing stale commits behind a trap.
module exc_commit #(
    parameter int PC_W      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [PC_W-1:0]      ms_pc,
    input  logic [PC_W-1:0]      ms_vaddr,
    input  logic [4:0]           ms_exc_flags,
    input  logic                 ms_ertn,
    input  logic                 ms_rf_we,
    input  logic [RF_ADDR_W-1:0] ms_rf_waddr,
    input  logic [31:0]          ms_rf_wdata,

    input  logic                 INT_signal,

    output logic                 EXC_signal,
    output logic                 ERTN_signal,
    output logic [5:0]           EXC_ecode,
    output logic [8:0]           EXC_esubcode,
    output logic [PC_W-1:0]      EXC_pc,
    output logic [PC_W-1:0]      EXC_vaddr,

    output logic                 flush,

    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [31:0]          rf_wdata
);

    // Flag bit positions within ms_exc_flags.
    localparam int unsigned F_ADEF = 0;
    localparam int unsigned F_INE  = 1;
    localparam int unsigned F_SYS  = 2;
    localparam int unsigned F_BRK  = 3;
    localparam int unsigned F_ALE  = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   ws_valid;
    logic [PC_W-1:0]        ws_pc;
    logic [PC_W-1:0]        ws_vaddr;
    logic [4:0]             ws_flags;
    logic                   ws_ertn;
    logic                   ws_rf_we;
    logic [RF_ADDR_W-1:0]   ws_rf_waddr;
    logic [31:0]            ws_rf_wdata;

    // State register and WB pipeline register; a flush squashes whatever MEM offers on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            ws_valid    <= 1'b0;
            ws_pc       <= '0;
            ws_vaddr    <= '0;
            ws_flags    <= '0;
            ws_ertn     <= 1'b0;
            ws_rf_we    <= 1'b0;
            ws_rf_waddr <= '0;
            ws_rf_wdata <= '0;
        end else begin
            state <= state_next;
            if (flush || !ws_allowin) begin
                ws_valid <= 1'b0;
            end else begin
                ws_valid <= ms_to_ws_valid;
                if (ms_to_ws_valid) begin
                    ws_pc       <= ms_pc;
                    ws_vaddr    <= ms_vaddr;
                    ws_flags    <= ms_exc_flags;
                    ws_ertn     <= ms_ertn;
                    ws_rf_we    <= ms_rf_we;
                    ws_rf_waddr <= ms_rf_waddr;
                    ws_rf_wdata <= ms_rf_wdata;
                end
            end
        end
    end

    // Commit decode, flush generation and next-state; everything is held at zero in FLUSH.
    always_comb begin
        state_next   = state;
        ws_allowin   = 1'b0;
        EXC_signal   = 1'b0;
        ERTN_signal  = 1'b0;
        EXC_ecode    = '0;
        EXC_esubcode = '0;
        EXC_pc       = '0;
        EXC_vaddr    = '0;
        flush        = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;

        if (state == S_RUN) begin
            ws_allowin = 1'b1;
            EXC_pc     = ws_pc;
            EXC_vaddr  = ws_vaddr;
            rf_waddr   = ws_rf_waddr;
            rf_wdata   = ws_rf_wdata;

            if (ws_valid) begin
                EXC_signal = 1'b1;
                if (INT_signal)             EXC_ecode = ECODE_INT;
                else if (ws_flags[F_ADEF])  EXC_ecode = ECODE_ADEF;
                else if (ws_flags[F_INE])   EXC_ecode = ECODE_INE;
                else if (ws_flags[F_SYS])   EXC_ecode = ECODE_SYS;
                else if (ws_flags[F_BRK])   EXC_ecode = ECODE_BRK;
                else if (ws_flags[F_ALE])   EXC_ecode = ECODE_ALE;
                else                        EXC_signal = 1'b0;

                ERTN_signal = ws_ertn && !EXC_signal;
                rf_we       = ws_rf_we && !EXC_signal;
            end

            flush = EXC_signal || ERTN_signal;
            if (flush) begin
                state_next = S_FLUSH;
            end
        end else begin
            state_next = S_RUN;
        end
    end

endmodule
